// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on input and output.
// Single-cycle opcodes go IDLE -> DONE; MUL/MULHU iterate one bit per cycle
// in BUSY over a 2*WIDTH accumulator.
// Build option: define ALU_MC_DIV_EN to compile in the restoring divider for
// DIVU/REMU; without it those opcodes behave as undefined (err=1, result=0).
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [2*WIDTH-1:0]     acc_r, acc_nxt_s, mul_nxt_s;
  logic [WIDTH:0]         mul_sum_s;
  logic [WIDTH-1:0]       b_r, result_r, alu_res_s, fin_s;
  logic [3:0]             opr_r;
  logic [CW-1:0]          cnt_r;
  logic                   err_r, alu_err_s, iter_s, hi_sel_s;
  logic [SHW-1:0]         shamt_s;
`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0]         div_rem_s, div_dif_s;
  logic [2*WIDTH-1:0]     div_nxt_s;
`endif

  // Opcodes that run through the iterative BUSY datapath.
  function automatic logic is_iter(input logic [3:0] op);
    case (op)
      OP_MUL, OP_MULHU: is_iter = 1'b1;
`ifdef ALU_MC_DIV_EN
      OP_DIVU, OP_REMU: is_iter = 1'b1;
`endif
      default:          is_iter = 1'b0;
    endcase
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign result    = result_r;
  assign err       = err_r;
  assign iter_s    = is_iter(opr);
  assign shamt_s   = b[SHW-1:0];

  // Single-cycle result computed straight from the request operands.
  always_comb begin
    alu_res_s = '0;
    alu_err_s = 1'b0;
    case (opr)
      OP_ADD:  alu_res_s = a + b;
      OP_SUB:  alu_res_s = a - b;
      OP_SLL:  alu_res_s = a << shamt_s;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  alu_res_s = a ^ b;
      OP_SRL:  alu_res_s = a >> shamt_s;
      OP_SRA:  alu_res_s = $signed(a) >>> shamt_s;
      OP_OR:   alu_res_s = a | b;
      OP_AND:  alu_res_s = a & b;
      OP_MUL, OP_MULHU: alu_res_s = '0;
      default: begin
        alu_res_s = '0;
        alu_err_s = 1'b1;
      end
    endcase
  end

  // One shift-add step: add multiplicand into the high half when the LSB is set, then shift right.
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    mul_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
  end

`ifdef ALU_MC_DIV_EN
  // One restoring-division step: shift in next dividend bit, subtract divisor if it fits.
  always_comb begin
    div_rem_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_dif_s = div_rem_s - {1'b0, b_r};
    if (div_dif_s[WIDTH]) begin
      div_nxt_s = {div_rem_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end else begin
      div_nxt_s = {div_dif_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
  end
`endif

  // Pick the iteration step for the captured opcode and which accumulator half is the answer.
  always_comb begin
`ifdef ALU_MC_DIV_EN
    if ((opr_r == OP_DIVU) || (opr_r == OP_REMU)) begin
      acc_nxt_s = div_nxt_s;
    end else begin
      acc_nxt_s = mul_nxt_s;
    end
    hi_sel_s = (opr_r == OP_MULHU) || (opr_r == OP_REMU);
`else
    acc_nxt_s = mul_nxt_s;
    hi_sel_s  = (opr_r == OP_MULHU);
`endif
    if (hi_sel_s) begin
      fin_s = acc_nxt_s[2*WIDTH-1:WIDTH];
    end else begin
      fin_s = acc_nxt_s[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: accept only in IDLE, leave DONE on the consumer handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (iter_s) begin
            state_nxt_s = BUSY;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in BUSY, hold result/err until the next operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= '0;
      b_r      <= '0;
      opr_r    <= 4'd0;
      cnt_r    <= '0;
      result_r <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            opr_r <= opr;
            b_r   <= b;
            acc_r <= {{WIDTH{1'b0}}, a};
            cnt_r <= '0;
            if (!iter_s) begin
              result_r <= alu_res_s;
              err_r    <= alu_err_s;
            end
          end
        end
        BUSY: begin
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            result_r <= fin_s;
            err_r    <= 1'b0;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which sets the operand/result width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have ports a, b  input  WIDTH each, carrying the operands.
REQ-007 SHALL have port opr  input  4  opcode.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  WIDTH  operation result.
REQ-011 SHALL have port err  output  1  unsupported opcode flag, qualified by out_valid.

Function
REQ-012 SHALL decode opr as follows:
- 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR.
- 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
- 1001 MUL (low WIDTH bits of the product), 1011 MULHU (high WIDTH bits of the unsigned product).
- 1100 DIVU, 1110 REMU.
REQ-013 SHALL take the shift amount from b[log2(WIDTH)-1:0] only.
REQ-014 SHALL wrap ADD/SUB modulo 2^WIDTH; SLT/SLTU return 1 or 0, zero-extended.
REQ-015 SHALL implement an FSM with states IDLE, BUSY, DONE; in_ready = (state==IDLE).
REQ-016 SHALL capture a, b and opr on a handshake (in_valid && in_ready); inputs are ignored at all other times.
REQ-017 Single-cycle opcodes and undefined opcodes (1010, 1111) SHALL go IDLE -> DONE, giving out_valid on the cycle after acceptance.
REQ-018 MUL/MULHU SHALL use an iterative shift-add over a 2*WIDTH accumulator, one bit per cycle: IDLE -> BUSY for exactly WIDTH cycles -> DONE; out_valid asserts WIDTH+1 cycles after acceptance.
REQ-019 DIVU/REMU SHALL use an iterative restoring division, one quotient bit per cycle, with the same WIDTH+1 latency.
REQ-020 For divide by zero: DIVU result = all ones and REMU result = a, with the full latency and err=0.
REQ-021 Undefined opcodes SHALL give result=0 and err=1.
REQ-022 In DONE, result and err SHALL hold stable while out_valid && !out_ready.
REQ-023 DONE SHALL go to IDLE on out_ready; a new request is accepted no earlier than the following cycle (no same-cycle turnaround).
REQ-024 SHALL tolerate in_valid asserted during BUSY or DONE: not accepted, no effect, request pending.
REQ-025 Iteration counter SHALL be ceil(log2(WIDTH+1)) bits and clear on entry to BUSY.

Reset
REQ-026 Asserting rst SHALL immediately force state=IDLE, out_valid=0, result=0, err=0 and counter=0, regardless of state or clock.
REQ-027 Reset mid-operation (BUSY or DONE) SHALL discard the operation; no result is ever presented for it.
REQ-028 SHALL drive in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-029 Macro ALU_MC_DIV_EN, when defined, SHALL compile in the divider, making DIVU/REMU behave per REQ-019/020.
REQ-030 With ALU_MC_DIV_EN undefined, DIVU/REMU SHALL be treated as undefined opcodes (REQ-017/021: 1-cycle latency, result=0, err=1) and no divider logic is instantiated.

Verification (WIDTH=32, out_ready=1 unless stated)
REQ-031 ADD a=10 b=5; SRA a=-8 b=2; SLTU a=FFFFFFFF b=1 -> results 15, -2 (FFFFFFFE), 0, each with out_valid 1 cycle after accept and err=0.
REQ-032 MUL a=FFFFFFFF b=FFFFFFFF; MULHU same operands -> results 00000001 and FFFFFFFE, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-033 With ALU_MC_DIV_EN: DIVU a=100 b=7 -> 14; REMU -> 2; DIVU b=0 -> FFFFFFFF; REMU a=9 b=0 -> 9, latency 33. Without the macro: DIVU a=100 b=7 -> result 0, err=1, latency 1.
REQ-034 opr=1111 -> result 0, err=1; then out_ready=0 for 5 cycles -> result/err/out_valid stable; in_valid held high with new operands is not accepted until 1 cycle after the out_ready handshake.
REQ-035 rst pulsed at cycle 10 of a MUL -> out_valid=0 and result=0 immediately; in_ready=1 after release; a following ADD 2+3 returns 5 with no stale output.
REQ-036 WIDTH=8 build: SLL a=1 b=0x0B (shift 3) -> 08; MUL a=FF b=02 -> FE, latency 9.
